// File: rtl/serial_subtractor_if.sv
// Start/done bus for the bit-serial subtractor; carries operands in, the held result
// and the FSM state (for checkers) out.
interface serial_subtractor_if #(
  parameter int WIDTH = 4
);
  // Handshake: start is sampled on each rising clk edge but is taken only while the FSM is in IDLE.
  // A and B are captured on that same accepting edge. busy stays high for the WIDTH shift cycles.
  // done pulses for one cycle exactly when D/Bout take the new result, and D/Bout then hold.
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] D;
  logic             Bout;
  logic [1:0]       state_dbg;

  modport master (
    output start, A, B,
    input  busy, done, D, Bout, state_dbg
  );

  modport slave (
    input  start, A, B,
    output busy, done, D, Bout, state_dbg
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial A - B, LSB first: one registered full-subtractor step per clock.
// A borrow flop links the steps, and the result is published on D/Bout only when the last bit is done.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_sr_q;
  logic [WIDTH-1:0] b_sr_q;
  logic [WIDTH-1:0] r_sr_q;
  logic [WIDTH-1:0] d_q;
  logic             br_q;
  logic             bout_q;
  logic [CW-1:0]    cnt_q;

  logic             a0;
  logic             b0;
  logic             diff_d;
  logic             br_d;
  logic [WIDTH:0]   r_ext;
  logic [WIDTH-1:0] r_sr_d;
  logic             last_bit;

  assign a0     = a_sr_q[0];
  assign b0     = b_sr_q[0];
  assign diff_d = a0 ^ b0 ^ br_q;
  assign br_d   = (~a0 & b0) | (~(a0 ^ b0) & br_q);

  // The new difference bit enters at the MSB. The extended vector keeps this legal when WIDTH is 1.
  assign r_ext    = {diff_d, r_sr_q};
  assign r_sr_d   = r_ext[WIDTH:1];
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      r_sr_q  <= '0;
      d_q     <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_sr_q  <= bus.A;
            b_sr_q  <= bus.B;
            r_sr_q  <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          a_sr_q <= a_sr_q >> 1;
          b_sr_q <= b_sr_q >> 1;
          r_sr_q <= r_sr_d;
          br_q   <= br_d;
          cnt_q  <= cnt_q + CW'(1);
          if (last_bit) begin
            d_q     <= r_sr_d;
            bout_q  <= br_d;
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = (state_q == SHIFT);
  assign bus.done      = (state_q == DONE);
  assign bus.D         = d_q;
  assign bus.Bout      = bout_q;
  assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: a WIDTH=4 instance and a WIDTH=1 instance share one clock and reset.
module tb_serial_subtractor;
  logic clk;
  logic rst_n;
  int   cyc;
  int   n_chk;
  int   n_err;
  logic [4:0] exp_q[$];

  serial_subtractor_if #(.WIDTH(4)) if4 ();
  serial_subtractor_if #(.WIDTH(1)) if1 ();

  serial_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
  serial_subtractor #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit w1, input logic [3:0] a, input logic [3:0] b, input logic s);
    if (w1) begin
      if1.start = s;
      if1.A     = a[0:0];
      if1.B     = b[0:0];
    end else begin
      if4.start = s;
      if4.A     = a;
      if4.B     = b;
    end
  endtask

  function automatic logic get_busy(input bit w1);
    return w1 ? if1.busy : if4.busy;
  endfunction

  function automatic logic get_done(input bit w1);
    return w1 ? if1.done : if4.done;
  endfunction

  function automatic logic [3:0] get_d(input bit w1);
    return w1 ? {3'b000, if1.D} : if4.D;
  endfunction

  function automatic logic get_bout(input bit w1);
    return w1 ? if1.Bout : if4.Bout;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One subtraction: checks latency, busy width, result, and the single-cycle done pulse.
  task automatic run_op(input bit w1, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] ed, input logic eb, input string tag);
    int width;
    int n;
    int busy_cnt;
    width    = w1 ? 1 : 4;
    n        = 0;
    busy_cnt = 0;
    drive(w1, a, b, 1'b1);
    tick();
    drive(w1, ~a, ~b, 1'b0);
    while (!get_done(w1) && n < 20) begin
      if (get_busy(w1)) busy_cnt++;
      tick();
      n++;
    end
    check({tag, "_latency"}, n, width);
    check({tag, "_busy_cycles"}, busy_cnt, width);
    check({tag, "_busy_at_done"}, {31'd0, get_busy(w1)}, 0);
    check({tag, "_d"}, {28'd0, get_d(w1)}, {28'd0, ed});
    check({tag, "_bout"}, {31'd0, get_bout(w1)}, {31'd0, eb});
    tick();
    check({tag, "_done_width"}, {31'd0, get_done(w1)}, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int dones;
    int d_bad;
    int n;
    int prev;
    logic [4:0] got5;

    n_chk = 0;
    n_err = 0;
    cyc   = 0;
    rst_n = 1'b0;
    drive(1'b0, 4'd0, 4'd0, 1'b0);
    drive(1'b1, 4'd0, 4'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, if4.busy}, 0);
    check("rst_done", {31'd0, if4.done}, 0);
    check("rst_d", {28'd0, if4.D}, 0);
    check("rst_bout", {31'd0, if4.Bout}, 0);
    check("rst_state", {30'd0, if4.state_dbg}, 0);
    rst_n = 1'b1;
    tick();

    run_op(1'b0, 4'd9, 4'd3, 4'd6, 1'b0, "op_9_3");
    run_op(1'b0, 4'd3, 4'd9, 4'hA, 1'b1, "op_3_9");
    run_op(1'b0, 4'd0, 4'd1, 4'hF, 1'b1, "op_0_1");
    run_op(1'b0, 4'd15, 4'd15, 4'd0, 1'b0, "op_15_15");

    run_op(1'b1, 4'd1, 4'd0, 4'd1, 1'b0, "w1_1_0");
    run_op(1'b1, 4'd0, 4'd1, 4'd1, 1'b1, "w1_0_1");

    // A second start while busy must be dropped, not queued.
    drive(1'b0, 4'd5, 4'd2, 1'b1);
    tick();
    drive(1'b0, 4'd5, 4'd2, 1'b0);
    tick();
    drive(1'b0, 4'd1, 4'd7, 1'b1);
    tick();
    drive(1'b0, 4'd1, 4'd7, 1'b0);
    dones = 0;
    d_bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (if4.done) dones++;
      if (dones > 0 && (if4.D !== 4'd3 || if4.Bout !== 1'b0)) d_bad++;
      tick();
    end
    check("ign_done_count", dones, 1);
    check("ign_hold_bad_cycles", d_bad, 0);
    check("ign_d", {28'd0, if4.D}, 3);
    check("ign_bout", {31'd0, if4.Bout}, 0);

    // Abort two cycles into an operation.
    drive(1'b0, 4'd12, 4'd4, 1'b1);
    tick();
    drive(1'b0, 4'd12, 4'd4, 1'b0);
    tick();
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, if4.busy}, 0);
    check("abort_done", {31'd0, if4.done}, 0);
    check("abort_d", {28'd0, if4.D}, 0);
    check("abort_bout", {31'd0, if4.Bout}, 0);
    check("abort_w1_d", {31'd0, if1.D}, 0);
    check("abort_w1_bout", {31'd0, if1.Bout}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    run_op(1'b0, 4'd8, 4'd8, 4'd0, 1'b0, "post_rst_8_8");

    // Exhaustive sweep with start held high: one result every WIDTH+2 = 6 cycles.
    prev = -1;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        if4.A     = 4'(a);
        if4.B     = 4'(b);
        if4.start = 1'b1;
        exp_q.push_back(5'(a - b));
        n = 0;
        do begin
          tick();
          n++;
        end while (!if4.done && n < 20);
        check("sweep_done_seen", {31'd0, if4.done}, 1);
        got5 = {if4.Bout, if4.D};
        check("sweep_diff", {27'd0, got5}, {27'd0, exp_q.pop_front()});
        if (prev >= 0) check("sweep_spacing", cyc - prev, 6);
        prev = cyc;
      end
    end
    if4.start = 1'b0;
    repeat (3) tick();
    check("sweep_idle_busy", {31'd0, if4.busy}, 0);
    check("sweep_idle_state", {30'd0, if4.state_dbg}, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
